// File: rtl/sel_mux_reg_if.sv
// Bundle of the channel inputs, the select controls and the registered output of sel_mux_reg.
// There is no logic here: it only groups the wires and sets their directions.
// The master drives the inputs and out_ready. The slave (the mux) drives in_ready and the out_* signals.
interface sel_mux_reg_if #(
    parameter int WIDTH = 4,
    parameter int N     = 2
);
    localparam int SELW = (N > 1) ? $clog2(N) : 1;

    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [SELW-1:0]    sel;
    logic               mode;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_chan;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output in_data, in_valid, sel, mode, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

    modport slave (
        input  in_data, in_valid, sel, mode, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/sel_mux_reg.sv
// N-channel WIDTH-bit select/round-robin mux with a registered output stage and the index of the source channel.
// Latency: 1 clock from the input handshake to out_valid. It can move one word per cycle when drain and fill happen together.
// Back-pressure: when the output is full and out_ready is low, every in_ready is 0 and the output and rr_ptr hold.
module sel_mux_reg #(
    parameter int WIDTH = 4,
    parameter int N     = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    sel_mux_reg_if.slave  bus
);
    localparam int SELW = (N > 1) ? $clog2(N) : 1;

    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]  out_chan_q,  out_chan_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  rr_ptr_q,    rr_ptr_d;

    logic             load;
    logic [N-1:0]     grant;
    logic             xfer;
    logic [SELW-1:0]  gnt_idx;
    logic [WIDTH-1:0] gnt_data;

    // Pick the first valid channel, starting at ptr and wrapping from N-1 to 0.
    // The loops compare against constant indices, so the result is plain compare logic and needs no variable bit-select.
    function automatic logic [N-1:0] rr_pick(input logic [N-1:0] vld, input logic [SELW-1:0] ptr);
        logic [N-1:0] g;
        logic         found;
        int           idx;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            for (int i = 0; i < N; i++) begin
                if (!found && (idx == i) && vld[i]) begin
                    g[i]  = 1'b1;
                    found = 1'b1;
                end
            end
        end
        return g;
    endfunction

    // The output register can take a word when it is empty or is being drained in this cycle.
    assign load = !out_valid_q || bus.out_ready;

    // Grant is combinational from mode and sel. If sel is N or more, it matches no channel and nothing is granted.
    always_comb begin
        grant = '0;
        if (!bus.mode) begin
            for (int i = 0; i < N; i++) begin
                if (int'(bus.sel) == i) grant[i] = bus.in_valid[i];
            end
        end else begin
            grant = rr_pick(bus.in_valid, rr_ptr_q);
        end
    end

    // Ready is held low during reset so that no handshake can complete while the registers are cleared.
    assign bus.in_ready = rst_n ? (grant & {N{load}}) : '0;
    assign xfer         = |(bus.in_valid & bus.in_ready);

    // Encode the one-hot grant. The data is AND-OR muxed so that unselected channels, even if X, never reach the register.
    always_comb begin
        gnt_idx  = '0;
        gnt_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                gnt_idx  = SELW'(i);
                gnt_data = gnt_data | bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // A fill replaces the held word, even when it is being drained in the same cycle. A drain with no fill only clears valid.
    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            out_data_d  = gnt_data;
            out_chan_d  = gnt_idx;
            out_valid_d = 1'b1;
            if (bus.mode) begin
                rr_ptr_d = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + SELW'(1);
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output stage and round-robin pointer. Reset clears them immediately (asynchronous reset).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_sel_mux_reg.sv
// Directed bench for sel_mux_reg, with two instances: N=2 for fixed select and N=4 for round-robin.
// Every check compares against a value worked out by hand from the intended behaviour.
// Outputs are sampled 1 time unit after the rising edge, and inputs change at that same point.
module tb_sel_mux_reg;
    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    sel_mux_reg_if #(.WIDTH(4), .N(2)) ifa ();
    sel_mux_reg_if #(.WIDTH(4), .N(4)) ifb ();

    sel_mux_reg #(.WIDTH(4), .N(2)) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    sel_mux_reg #(.WIDTH(4), .N(4)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        ifa.in_data   = '0;
        ifa.in_valid  = '1;
        ifa.sel       = '0;
        ifa.mode      = 1'b0;
        ifa.out_ready = 1'b0;
        ifb.in_data   = '0;
        ifb.in_valid  = '1;
        ifb.sel       = '0;
        ifb.mode      = 1'b0;
        ifb.out_ready = 1'b0;
        #12;
        chk("rst_a_valid", ifa.out_valid, 0);
        chk("rst_a_data",  ifa.out_data,  0);
        chk("rst_a_chan",  ifa.out_chan,  0);
        chk("rst_a_rdy",   ifa.in_ready,  0);
        chk("rst_b_rdy",   ifb.in_ready,  0);

        // Fixed select on N=2: C1=0100, C0=0001, sel=1
        ifb.in_valid  = '0;
        ifa.in_data   = 8'b0100_0001;
        ifa.in_valid  = 2'b11;
        ifa.sel       = 1'b1;
        ifa.out_ready = 1'b1;
        rst_n         = 1'b1;
        #1;
        chk("fix_rdy_sel1", ifa.in_ready, 2'b10);
        step();
        chk("fix_data_sel1",  ifa.out_data,  4'b0100);
        chk("fix_chan_sel1",  ifa.out_chan,  1);
        chk("fix_valid_sel1", ifa.out_valid, 1);

        // Switching sel while streaming gives the new channel on the next edge, with no gap
        ifa.sel = 1'b0;
        #1;
        chk("fix_rdy_sel0", ifa.in_ready, 2'b01);
        step();
        chk("fix_data_sel0",  ifa.out_data,  4'b0001);
        chk("fix_chan_sel0",  ifa.out_chan,  0);
        chk("fix_valid_sel0", ifa.out_valid, 1);

        // Drain with no fill: valid drops and the data holds
        ifa.in_valid = 2'b00;
        step();
        chk("drain_valid", ifa.out_valid, 0);
        chk("drain_data",  ifa.out_data,  4'b0001);

        // Back-pressure: load A, then stall for 3 cycles while the inputs stay valid
        ifa.in_data  = {4'hA, 4'h5};
        ifa.in_valid = 2'b11;
        ifa.sel      = 1'b1;
        step();
        chk("bp_load_data",  ifa.out_data,  4'hA);
        chk("bp_load_valid", ifa.out_valid, 1);
        ifa.out_ready = 1'b0;
        ifa.in_data   = {4'hB, 4'h5};
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_rdy", ifa.in_ready, 2'b00);
            step();
            chk("bp_data",  ifa.out_data,  4'hA);
            chk("bp_valid", ifa.out_valid, 1);
        end
        ifa.out_ready = 1'b1;
        #1;
        chk("bp_release_rdy", ifa.in_ready, 2'b10);
        step();
        chk("bp_release_data",  ifa.out_data,  4'hB);
        chk("bp_release_valid", ifa.out_valid, 1);
        ifa.in_valid = 2'b00;
        step();

        // Round-robin fairness on N=4, with every channel valid
        ifb.in_data   = {4'hB, 4'hA, 4'h9, 4'h8};
        ifb.mode      = 1'b1;
        ifb.in_valid  = 4'b1111;
        ifb.out_ready = 1'b1;
        #1;
        chk("rr_first_rdy", ifb.in_ready, 4'b0001);
        for (int k = 0; k < 8; k++) begin
            step();
            chk("rr_chan",  ifb.out_chan,  k % 4);
            chk("rr_data",  ifb.out_data,  8 + (k % 4));
            chk("rr_valid", ifb.out_valid, 1);
        end

        // Set rr_ptr to 3 by taking channel 2, then only channel 1 is valid
        ifb.in_valid = 4'b0100;
        step();
        chk("rr_c2_chan", ifb.out_chan, 2);
        ifb.in_valid = 4'b0010;
        #1;
        chk("rr_wrap_rdy", ifb.in_ready, 4'b0010);
        step();
        chk("rr_wrap_chan", ifb.out_chan, 1);
        // rr_ptr is now 2; with 0101 valid, channel 2 wins over channel 0
        ifb.in_valid = 4'b0101;
        #1;
        chk("rr_skip_rdy", ifb.in_ready, 4'b0100);
        step();
        chk("rr_skip_chan", ifb.out_chan, 2);
        #1;
        chk("rr_skip2_rdy", ifb.in_ready, 4'b0001);
        step();
        chk("rr_skip2_chan", ifb.out_chan, 0);
        chk("rr_skip2_data", ifb.out_data, 4'h8);

        // Asynchronous reset between edges while the output is full, with rr_ptr at 1
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", ifb.out_valid, 0);
        chk("arst_data",  ifb.out_data,  0);
        chk("arst_chan",  ifb.out_chan,  0);
        chk("arst_rdy",   ifb.in_ready,  0);
        ifb.in_valid = 4'b1111;
        #2;
        rst_n = 1'b1;
        #1;
        chk("arst_rel_rdy",   ifb.in_ready,  4'b0001);
        chk("arst_rel_valid", ifb.out_valid, 0);
        step();
        chk("arst_first_valid", ifb.out_valid, 1);
        chk("arst_first_chan",  ifb.out_chan,  0);
        chk("arst_first_data",  ifb.out_data,  4'h8);
        step();
        chk("arst_second_chan", ifb.out_chan, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
